// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the ID/EX stage: FSM encoding, bubble
// control word and the ALU "register operand" select value.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } idex_state_e;

  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic [1:0] alusrc0;
    logic [1:0] alusrc1;
    logic [5:0] opcode;
  } idex_ctrl_t;

  localparam idex_ctrl_t BUBBLE_CTRL = '0;

  localparam logic [1:0] ALUSRC_REG = 2'b00;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection: a load in EX whose destination
// feeds a register source of the instruction currently in ID.
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int REG_W = 32
) (
  input  logic             idex_memread_i,
  input  logic             idex_regwrite_i,
  input  logic [REG_W-1:0] idex_rd_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic [1:0]       id_alusrc0_i,
  input  logic [1:0]       id_alusrc1_i,
  output logic             hazard_o
);

  logic rs_dep;
  logic rt_dep;

  // A source only matters when the ALU mux actually selects the register.
  assign rs_dep = (id_alusrc1_i == ALUSRC_REG) && (id_rs_i == idex_rd_i);
  assign rt_dep = (id_alusrc0_i == ALUSRC_REG) && (id_rt_i == idex_rd_i);

  assign hazard_o = idex_memread_i && idex_regwrite_i &&
                    (idex_rd_i != '0) && (rs_dep || rt_dep);

endmodule

// File: rtl/hazard_idex_stage.sv
// ID/EX pipeline register with load-use stall insertion, branch squash and a
// saturating count of hazard bubbles.
module hazard_idex_stage
  import pipe_pkg::*;
#(
  parameter int REG_W        = 32,
  parameter int DATA_W       = 32,
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [REG_W-1:0]  ID_RegisterRs,
  input  logic [REG_W-1:0]  ID_RegisterRt,
  input  logic [REG_W-1:0]  ID_RegisterRd,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic [1:0]        ID_ALUSrc0,
  input  logic [1:0]        ID_ALUSrc1,
  input  logic [5:0]        ID_OpCode,
  input  logic [DATA_W-1:0] ID_ReadData1,
  input  logic [DATA_W-1:0] ID_ReadData2,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic              EX_BranchTaken,
  output logic [REG_W-1:0]  IDEX_RegisterRs,
  output logic [REG_W-1:0]  IDEX_RegisterRt,
  output logic [REG_W-1:0]  IDEX_RegisterRd,
  output logic              IDEX_RegWrite,
  output logic              IDEX_MemRead,
  output logic              IDEX_MemWrite,
  output logic [1:0]        IDEX_ALUSrc0,
  output logic [1:0]        IDEX_ALUSrc1,
  output logic [5:0]        IDEX_OpCode,
  output logic [DATA_W-1:0] IDEX_ReadData1,
  output logic [DATA_W-1:0] IDEX_ReadData2,
  output logic [DATA_W-1:0] IDEX_Imm,
  output logic              PC_Write,
  output logic              IFID_Write,
  output logic              IFID_Flush,
  output logic [CNT_W-1:0]  StallCount
);

  idex_state_e       state_q, state_d;
  logic [1:0]        stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  stat_q, stat_d;

  idex_ctrl_t        ctrl_q, ctrl_d;
  logic [REG_W-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;

  logic hazard;
  logic load_id;
  logic count_bubble;

  load_use_detect #(
    .REG_W(REG_W)
  ) u_detect (
    .idex_memread_i (ctrl_q.memread),
    .idex_regwrite_i(ctrl_q.regwrite),
    .idex_rd_i      (rd_q),
    .id_rs_i        (ID_RegisterRs),
    .id_rt_i        (ID_RegisterRt),
    .id_alusrc0_i   (ID_ALUSrc0),
    .id_alusrc1_i   (ID_ALUSrc1),
    .hazard_o       (hazard)
  );

  always_comb begin
    state_d      = state_q;
    stall_cnt_d  = stall_cnt_q;
    load_id      = 1'b0;
    count_bubble = 1'b0;
    PC_Write     = 1'b1;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;

    // A taken branch wins over any hazard or stall in progress.
    if (EX_BranchTaken) begin
      IFID_Flush  = 1'b1;
      state_d     = ST_FLUSH;
      stall_cnt_d = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hazard) begin
            PC_Write     = 1'b0;
            IFID_Write   = 1'b0;
            count_bubble = 1'b1;
            if (STALL_CYCLES > 1) begin
              stall_cnt_d = 2'(STALL_CYCLES - 1);
              state_d     = ST_STALL;
            end
          end else begin
            load_id = 1'b1;
          end
        end
        ST_STALL: begin
          PC_Write     = 1'b0;
          IFID_Write   = 1'b0;
          count_bubble = 1'b1;
          if (stall_cnt_q <= 2'd1) begin
            stall_cnt_d = '0;
            state_d     = ST_RUN;
          end else begin
            stall_cnt_d = stall_cnt_q - 2'd1;
          end
        end
        ST_FLUSH: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    ctrl_d = BUBBLE_CTRL;
    rs_d   = '0;
    rt_d   = '0;
    rd_d   = '0;
    rd1_d  = '0;
    rd2_d  = '0;
    imm_d  = '0;
    if (load_id) begin
      ctrl_d = '{regwrite: ID_RegWrite, memread: ID_MemRead, memwrite: ID_MemWrite,
                 alusrc0: ID_ALUSrc0, alusrc1: ID_ALUSrc1, opcode: ID_OpCode};
      rs_d   = ID_RegisterRs;
      rt_d   = ID_RegisterRt;
      rd_d   = ID_RegisterRd;
      rd1_d  = ID_ReadData1;
      rd2_d  = ID_ReadData2;
      imm_d  = ID_Imm;
    end
  end

  assign stat_d = (count_bubble && (stat_q != '1)) ? stat_q + 1'b1 : stat_q;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      stat_q      <= '0;
      ctrl_q      <= BUBBLE_CTRL;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      stat_q      <= stat_d;
      ctrl_q      <= ctrl_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      imm_q       <= imm_d;
    end
  end

  assign IDEX_RegisterRs = rs_q;
  assign IDEX_RegisterRt = rt_q;
  assign IDEX_RegisterRd = rd_q;
  assign IDEX_RegWrite   = ctrl_q.regwrite;
  assign IDEX_MemRead    = ctrl_q.memread;
  assign IDEX_MemWrite   = ctrl_q.memwrite;
  assign IDEX_ALUSrc0    = ctrl_q.alusrc0;
  assign IDEX_ALUSrc1    = ctrl_q.alusrc1;
  assign IDEX_OpCode     = ctrl_q.opcode;
  assign IDEX_ReadData1  = rd1_q;
  assign IDEX_ReadData2  = rd2_q;
  assign IDEX_Imm        = imm_q;
  assign StallCount      = stat_q;

endmodule

// File: tb/tb_hazard_idex_stage.sv
// Directed bench for hazard_idex_stage: one instance with single-cycle stalls
// and a 4-bit counter, one with three-cycle stalls; inputs are shared.
module tb_hazard_idex_stage;

  typedef struct packed {
    logic [31:0] rs, rt, rd;
    logic        rw, mr, mw;
    logic [1:0]  s0, s1;
    logic [5:0]  op;
    logic [31:0] d1, d2, imm;
  } instr_t;

  localparam instr_t NOP   = '0;
  localparam instr_t LW8   = '{rs: 32'd1, rt: 32'd8, rd: 32'd8, rw: 1'b1, mr: 1'b1, mw: 1'b0,
                               s0: 2'b01, s1: 2'b00, op: 6'h23, d1: 32'h0000_1000, d2: 32'h0,
                               imm: 32'h4};
  localparam instr_t LW0   = '{rs: 32'd1, rt: 32'd0, rd: 32'd0, rw: 1'b1, mr: 1'b1, mw: 1'b0,
                               s0: 2'b01, s1: 2'b00, op: 6'h23, d1: 32'h0000_2000, d2: 32'h0,
                               imm: 32'h8};
  localparam instr_t ADD   = '{rs: 32'd8, rt: 32'd2, rd: 32'd10, rw: 1'b1, mr: 1'b0, mw: 1'b0,
                               s0: 2'b00, s1: 2'b00, op: 6'h00, d1: 32'hAAAA_0001,
                               d2: 32'h5555_0002, imm: 32'h0};
  localparam instr_t ADD0  = '{rs: 32'd0, rt: 32'd0, rd: 32'd11, rw: 1'b1, mr: 1'b0, mw: 1'b0,
                               s0: 2'b00, s1: 2'b00, op: 6'h00, d1: 32'h1234_5678,
                               d2: 32'h9ABC_DEF0, imm: 32'h0};
  localparam instr_t RT_IMM = '{rs: 32'd3, rt: 32'd8, rd: 32'd12, rw: 1'b1, mr: 1'b0, mw: 1'b0,
                               s0: 2'b01, s1: 2'b00, op: 6'h08, d1: 32'h0000_0033,
                               d2: 32'h0000_0088, imm: 32'h77};
  localparam instr_t RS_UNUSED = '{rs: 32'd8, rt: 32'd4, rd: 32'd14, rw: 1'b1, mr: 1'b0,
                               mw: 1'b0, s0: 2'b01, s1: 2'b10, op: 6'h0F, d1: 32'hDEAD_BEEF,
                               d2: 32'hCAFE_F00D, imm: 32'h1};
  localparam instr_t RT_DEP = '{rs: 32'd3, rt: 32'd8, rd: 32'd13, rw: 1'b1, mr: 1'b0, mw: 1'b1,
                               s0: 2'b00, s1: 2'b00, op: 6'h2B, d1: 32'h0000_0033,
                               d2: 32'h0000_0088, imm: 32'h0};

  logic        Clk = 1'b0;
  logic        Reset;
  logic        branch;
  logic [31:0] id_rs, id_rt, id_rd, id_d1, id_d2, id_imm;
  logic        id_rw, id_mr, id_mw;
  logic [1:0]  id_s0, id_s1;
  logic [5:0]  id_op;

  logic [31:0] a_rs, a_rt, a_rd, a_d1, a_d2, a_imm;
  logic        a_rw, a_mr, a_mw, a_pcw, a_ifw, a_flush;
  logic [1:0]  a_s0, a_s1;
  logic [5:0]  a_op;
  logic [3:0]  a_cnt;

  logic [31:0] b_rs, b_rt, b_rd, b_d1, b_d2, b_imm;
  logic        b_rw, b_mr, b_mw, b_pcw, b_ifw, b_flush;
  logic [1:0]  b_s0, b_s1;
  logic [5:0]  b_op;
  logic [15:0] b_cnt;

  instr_t a_o, b_o;
  assign a_o = {a_rs, a_rt, a_rd, a_rw, a_mr, a_mw, a_s0, a_s1, a_op, a_d1, a_d2, a_imm};
  assign b_o = {b_rs, b_rt, b_rd, b_rw, b_mr, b_mw, b_s0, b_s1, b_op, b_d1, b_d2, b_imm};

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  hazard_idex_stage #(
    .REG_W(32), .DATA_W(32), .STALL_CYCLES(1), .CNT_W(4)
  ) dut_a (
    .Clk(Clk), .Reset(Reset),
    .ID_RegisterRs(id_rs), .ID_RegisterRt(id_rt), .ID_RegisterRd(id_rd),
    .ID_RegWrite(id_rw), .ID_MemRead(id_mr), .ID_MemWrite(id_mw),
    .ID_ALUSrc0(id_s0), .ID_ALUSrc1(id_s1), .ID_OpCode(id_op),
    .ID_ReadData1(id_d1), .ID_ReadData2(id_d2), .ID_Imm(id_imm),
    .EX_BranchTaken(branch),
    .IDEX_RegisterRs(a_rs), .IDEX_RegisterRt(a_rt), .IDEX_RegisterRd(a_rd),
    .IDEX_RegWrite(a_rw), .IDEX_MemRead(a_mr), .IDEX_MemWrite(a_mw),
    .IDEX_ALUSrc0(a_s0), .IDEX_ALUSrc1(a_s1), .IDEX_OpCode(a_op),
    .IDEX_ReadData1(a_d1), .IDEX_ReadData2(a_d2), .IDEX_Imm(a_imm),
    .PC_Write(a_pcw), .IFID_Write(a_ifw), .IFID_Flush(a_flush), .StallCount(a_cnt)
  );

  hazard_idex_stage #(
    .REG_W(32), .DATA_W(32), .STALL_CYCLES(3), .CNT_W(16)
  ) dut_b (
    .Clk(Clk), .Reset(Reset),
    .ID_RegisterRs(id_rs), .ID_RegisterRt(id_rt), .ID_RegisterRd(id_rd),
    .ID_RegWrite(id_rw), .ID_MemRead(id_mr), .ID_MemWrite(id_mw),
    .ID_ALUSrc0(id_s0), .ID_ALUSrc1(id_s1), .ID_OpCode(id_op),
    .ID_ReadData1(id_d1), .ID_ReadData2(id_d2), .ID_Imm(id_imm),
    .EX_BranchTaken(branch),
    .IDEX_RegisterRs(b_rs), .IDEX_RegisterRt(b_rt), .IDEX_RegisterRd(b_rd),
    .IDEX_RegWrite(b_rw), .IDEX_MemRead(b_mr), .IDEX_MemWrite(b_mw),
    .IDEX_ALUSrc0(b_s0), .IDEX_ALUSrc1(b_s1), .IDEX_OpCode(b_op),
    .IDEX_ReadData1(b_d1), .IDEX_ReadData2(b_d2), .IDEX_Imm(b_imm),
    .PC_Write(b_pcw), .IFID_Write(b_ifw), .IFID_Flush(b_flush), .StallCount(b_cnt)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input instr_t i);
    id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
    id_rw = i.rw; id_mr = i.mr; id_mw = i.mw;
    id_s0 = i.s0; id_s1 = i.s1; id_op = i.op;
    id_d1 = i.d1; id_d2 = i.d2; id_imm = i.imm;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    drive(NOP);
    tick();
    Reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    Reset  = 1'b0;
    branch = 1'b0;
    drive(NOP);
    tick();
    tick();
    check("rst_a_idex", a_o, NOP);
    check("rst_a_ctl", {a_pcw, a_ifw, a_flush}, 3'b110);
    check("rst_a_cnt", a_cnt, 4'd0);
    check("rst_b_idex", b_o, NOP);
    check("rst_b_cnt", b_cnt, 16'd0);
    Reset = 1'b1;

    // Single-cycle load-use stall on Rs.
    drive(LW8);
    #1 check("t1_no_haz_pcw", a_pcw, 1'b1);
    tick();
    check("t1_lw_loaded", a_o, LW8);
    drive(ADD);
    #1 check("t1_haz_ctl", {a_pcw, a_ifw, a_flush}, 3'b000);
    tick();
    check("t1_bubble", a_o, NOP);
    check("t1_cnt", a_cnt, 4'd1);
    check("t1_release_ctl", {a_pcw, a_ifw}, 2'b11);
    tick();
    check("t1_dep_loaded", a_o, ADD);
    check("t1_cnt_hold", a_cnt, 4'd1);

    // Three-cycle stall.
    do_reset();
    drive(LW8);
    tick();
    check("t2_lw_loaded", b_o, LW8);
    drive(ADD);
    #1 check("t2_haz_pcw", b_pcw, 1'b0);
    tick();
    check("t2_bub1", b_o, NOP);
    check("t2_cnt1", b_cnt, 16'd1);
    check("t2_stall1_ctl", {b_pcw, b_ifw}, 2'b00);
    tick();
    check("t2_bub2", b_o, NOP);
    check("t2_cnt2", b_cnt, 16'd2);
    check("t2_stall2_ctl", {b_pcw, b_ifw}, 2'b00);
    tick();
    check("t2_bub3", b_o, NOP);
    check("t2_cnt3", b_cnt, 16'd3);
    check("t2_run_ctl", {b_pcw, b_ifw}, 2'b11);
    tick();
    check("t2_dep_loaded", b_o, ADD);
    check("t2_cnt_final", b_cnt, 16'd3);

    // No stall: load to r0, unused Rt/Rs sources; then a real Rt hazard.
    do_reset();
    drive(LW0);
    tick();
    drive(ADD0);
    #1 check("t3_r0_pcw", a_pcw, 1'b1);
    tick();
    check("t3_r0_loaded", a_o, ADD0);
    check("t3_r0_cnt", a_cnt, 4'd0);
    drive(LW8);
    tick();
    drive(RT_IMM);
    #1 check("t3_rtimm_ctl", {a_pcw, a_ifw}, 2'b11);
    tick();
    check("t3_rtimm_loaded", a_o, RT_IMM);
    drive(LW8);
    tick();
    drive(RS_UNUSED);
    #1 check("t3_rsunused_pcw", a_pcw, 1'b1);
    tick();
    check("t3_rsunused_loaded", a_o, RS_UNUSED);
    drive(LW8);
    tick();
    drive(RT_DEP);
    #1 check("t3_rtdep_ctl", {a_pcw, a_ifw}, 2'b00);
    tick();
    check("t3_rtdep_bubble", a_o, NOP);
    check("t3_rtdep_cnt", a_cnt, 4'd1);

    // Branch taken while stalled.
    do_reset();
    drive(LW8);
    tick();
    drive(ADD);
    tick();
    tick();
    check("t4_cnt_before", b_cnt, 16'd2);
    branch = 1'b1;
    #1 check("t4_branch_ctl", {b_pcw, b_ifw, b_flush}, 3'b111);
    tick();
    branch = 1'b0;
    check("t4_bubble", b_o, NOP);
    check("t4_cnt_stop", b_cnt, 16'd2);
    #1 check("t4_flush_ctl", {b_pcw, b_ifw, b_flush}, 3'b110);
    tick();
    check("t4_flush_bubble", b_o, NOP);
    tick();
    check("t4_run_loaded", b_o, ADD);
    check("t4_cnt_final", b_cnt, 16'd2);

    // Reset mid-stall.
    do_reset();
    drive(LW8);
    tick();
    drive(ADD);
    tick();
    check("t5_in_stall", b_pcw, 1'b0);
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    #1;
    check("t5_idex", b_o, NOP);
    check("t5_cnt", b_cnt, 16'd0);
    check("t5_ctl", {b_pcw, b_ifw, b_flush}, 3'b110);
    tick();
    check("t5_run_loaded", b_o, ADD);

    // Saturation of the 4-bit counter.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(LW8);
      tick();
      drive(ADD);
      tick();
      tick();
      if (i == 14) check("t6_cnt_15", a_cnt, 4'd15);
    end
    check("t6_cnt_sat", a_cnt, 4'd15);
    check("t6_last_loaded", a_o, ADD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_idex_stage.md
Name: hazard_idex_stage

Overview:
- ID/EX pipeline register with built-in load-use hazard detection; sits directly upstream of the forwarding unit and the EX-stage ALU input muxes.
- Registers decoded ID-stage fields and produces the IDEX_RegisterRs/Rt/Rd, RegWrite and ALUSrc values that the forwarding unit compares.
- Stalls IF/ID and inserts bubbles for load-use hazards, which forwarding cannot cover.
- Squashes the ID/EX and IF/ID contents on a taken branch resolved in EX.

Parameters:
- REG_W, 32, width of register-specifier fields (matches the forwarding-unit compare width)
- DATA_W, 32, width of operand/immediate datapath
- STALL_CYCLES, 1, bubble cycles inserted per load-use hazard (1..3)
- CNT_W, 16, width of the stall statistics counter

Ports:
- Clk  in  1  pipeline clock, all state on rising edge
- Reset  in  1  synchronous, active-low reset
- ID_RegisterRs / ID_RegisterRt / ID_RegisterRd  in  REG_W each  decoded register specifiers
- ID_RegWrite, ID_MemRead, ID_MemWrite  in  1 each  decoded controls
- ID_ALUSrc0, ID_ALUSrc1  in  2 each  ALU source selects (ALUSrc1==0 means Rs is used; ALUSrc0==0 means Rt is used)
- ID_OpCode  in  6  opcode
- ID_ReadData1, ID_ReadData2, ID_Imm  in  DATA_W each  operands
- EX_BranchTaken  in  1  branch resolved taken in EX this cycle
- IDEX_RegisterRs / IDEX_RegisterRt / IDEX_RegisterRd  out  REG_W  registered specifiers
- IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite  out  1  registered controls
- IDEX_ALUSrc0, IDEX_ALUSrc1  out  2; IDEX_OpCode  out  6
- IDEX_ReadData1, IDEX_ReadData2, IDEX_Imm  out  DATA_W
- PC_Write  out  1  0 = hold PC
- IFID_Write  out  1  0 = hold IF/ID
- IFID_Flush  out  1  1 = zero IF/ID next edge
- StallCount  out  CNT_W  total bubble cycles inserted

Behaviour:
- Reset (Reset==0 at a clock edge):
  - All IDEX_* outputs are 0, which is a bubble.
  - PC_Write=1, IFID_Write=1, IFID_Flush=0, StallCount=0.
  - FSM goes to RUN.
  - Applies mid-stall as well; any in-progress stall is abandoned.
- Hazard (combinational, from current IDEX_* and ID_*):
  - Hazard = IDEX_MemRead & IDEX_RegWrite & (IDEX_RegisterRd != 0) & ( (ID_ALUSrc1==0 & ID_RegisterRs==IDEX_RegisterRd) | (ID_ALUSrc0==0 & ID_RegisterRt==IDEX_RegisterRd) ).
- FSM states: RUN, STALL, FLUSH.
- RUN:
  - No hazard and no branch: ID/EX loads all ID_* fields; PC_Write=1, IFID_Write=1.
  - Hazard: ID/EX loads a bubble (all controls and specifiers 0; data don't-care, driven 0); PC_Write=0, IFID_Write=0.
  - On a hazard, if STALL_CYCLES>1, load the down-counter with STALL_CYCLES-1 and go to STALL; otherwise stay in RUN and re-evaluate next cycle.
- STALL:
  - Keep inserting bubbles with PC_Write=0 and IFID_Write=0.
  - Decrement the counter; at 0, return to RUN and load the held ID instruction on the following edge.
- Branch priority: EX_BranchTaken=1 in any state overrides a hazard or stall.
  - ID/EX loads a bubble, IFID_Flush=1, PC_Write=1, IFID_Write=1.
  - Go to FLUSH for exactly one cycle, then to RUN.
  - Stall counter cleared.
- FLUSH: ID/EX loads a bubble (the flushed IF/ID now holds a NOP); IFID_Flush=0; then RUN.
- StallCount: +1 on each cycle a hazard bubble is inserted (RUN hazard or STALL). Branch bubbles are not counted. Saturates at all-ones; no wrap.
- Latency: one cycle, ID_* to IDEX_*.
- PC_Write, IFID_Write and IFID_Flush are combinational from state plus inputs so they act in the same cycle as the hazard.
- No hazard is reported when IDEX_RegisterRd==0, or when the matching source is unused (ALUSrc≠0).

Decomposition:
- Shared package pipe_pkg holds:
  - FSM state encoding (RUN=2'd0, STALL=2'd1, FLUSH=2'd2)
  - bubble control constant (all zero)
  - ALUSrc "register operand" constant 2'b00
- One sub-module, load_use_detect: the purely combinational Hazard equation, reusable by the forwarding-unit bench.
- Pipeline register and FSM stay in the top module.

Test Plan:
1. lw writes r8 (IDEX_MemRead=1, RegWrite=1, Rd=8), ID has Rs=8 with ALUSrc1=0 -> PC_Write=0 and IFID_Write=0 for 1 cycle, IDEX_* all 0 next edge, StallCount=1, dependent instruction enters ID/EX one cycle later.
2. Same as 1 with STALL_CYCLES=3 -> 3 consecutive bubbles, StallCount=3, then the ID instruction is loaded.
3. Load to r0, or ID Rt match with ALUSrc0=2'b01 -> no stall, ID fields registered unchanged, PC_Write stays 1.
4. EX_BranchTaken=1 during STALL (STALL_CYCLES=3, second bubble) -> IFID_Flush=1 that cycle, bubble loaded, FLUSH then RUN, StallCount stops at 2.
5. Reset=0 asserted mid-STALL -> next edge all IDEX_*=0, StallCount=0, PC_Write=1, state RUN.
6. Force StallCount to all-ones with CNT_W=4 (15 hazards) then one more hazard -> StallCount stays 15.
